// File: rtl/pla_pkg.sv
// Shared types and helpers for the programmable AND-plane.
// Readback build option: PLA_PROG_PLANE_READBACK_EN.
package pla_pkg;

  localparam int NIN_DEF   = 7;
  localparam int NROWS_DEF = 3;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  // Cared columns must equal the stored value; zero-extended operands.
  function automatic logic row_match(
    input logic [MAX_W-1:0] d,
    input logic [MAX_W-1:0] v,
    input logic [MAX_W-1:0] c
  );
    return ((d ^ v) & c) == '0;
  endfunction

endpackage

// File: rtl/pla_row_store.sv
// NROWS x (care,val) register file with a single write port.
// PLA_PROG_PLANE_READBACK_EN adds a registered readback port.
module pla_row_store
  import pla_pkg::*;
#(
  parameter int NIN   = NIN_DEF,
  parameter int NROWS = NROWS_DEF,
  parameter int CW    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [CW-1:0]              waddr,
  input  logic [NIN-1:0]             wcare,
  input  logic [NIN-1:0]             wval,
`ifdef PLA_PROG_PLANE_READBACK_EN
  input  logic [CW-1:0]              rd_row,
  output logic [NIN-1:0]             rd_care,
  output logic [NIN-1:0]             rd_val,
`endif
  output logic [NROWS-1:0][NIN-1:0]  care,
  output logic [NROWS-1:0][NIN-1:0]  val
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      care <= '0;
      val  <= '0;
    end else if (we) begin
      care[waddr] <= wcare;
      val[waddr]  <= wval;
    end
  end

`ifdef PLA_PROG_PLANE_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_care <= '0;
      rd_val  <= '0;
    end else if (int'(rd_row) < NROWS) begin
      rd_care <= care[rd_row];
      rd_val  <= val[rd_row];
    end else begin
      rd_care <= '0;
      rd_val  <= '0;
    end
  end
`endif

endmodule

// File: rtl/pla_prog_plane.sv
// Runtime-programmable AND-plane: streamed personality, 1-cycle evaluate.
// PLA_PROG_PLANE_READBACK_EN adds rd_row/rd_care/rd_val readback.
module pla_prog_plane
  import pla_pkg::*;
#(
  parameter int NIN   = NIN_DEF,
  parameter int NROWS = NROWS_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       prog_start,
  input  logic                                       prog_valid,
  output logic                                       prog_ready,
  input  logic [NIN-1:0]                             prog_care,
  input  logic [NIN-1:0]                             prog_val,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [NIN-1:0]                             in_data,
  output logic                                       out_valid,
  output logic [NROWS-1:0]                           out_data,
`ifdef PLA_PROG_PLANE_READBACK_EN
  input  logic [((NROWS > 1) ? $clog2(NROWS) : 1)-1:0] rd_row,
  output logic [NIN-1:0]                             rd_care,
  output logic [NIN-1:0]                             rd_val,
`endif
  output logic                                       armed
);

  localparam int CW = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NROWS - 1);

  state_t                     state;
  logic [CW-1:0]              row_cnt;
  logic [NROWS-1:0][NIN-1:0]  care;
  logic [NROWS-1:0][NIN-1:0]  val;
  logic [NROWS-1:0]           hit;
  logic                       wr_en;
  logic                       in_acc;

  // A row offered alongside prog_start is dropped by the restart.
  assign wr_en  = prog_valid & prog_ready & ~prog_start;
  assign in_acc = in_valid & in_ready;

  pla_row_store #(
    .NIN   (NIN),
    .NROWS (NROWS),
    .CW    (CW)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (row_cnt),
    .wcare   (prog_care),
    .wval    (prog_val),
`ifdef PLA_PROG_PLANE_READBACK_EN
    .rd_row  (rd_row),
    .rd_care (rd_care),
    .rd_val  (rd_val),
`endif
    .care    (care),
    .val     (val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      row_cnt    <= '0;
      prog_ready <= 1'b0;
      in_ready   <= 1'b0;
      armed      <= 1'b0;
    end else if (prog_start) begin
      state      <= ST_LOAD;
      row_cnt    <= '0;
      prog_ready <= 1'b1;
      in_ready   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (wr_en) begin
            if (row_cnt == LAST) begin
              state      <= ST_ARMED;
              row_cnt    <= '0;
              prog_ready <= 1'b0;
              in_ready   <= 1'b1;
              armed      <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ST_EMPTY, ST_ARMED: ;
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Row r lands on out_data[NROWS-1-r].
  always_comb begin
    hit = '0;
    for (int r = 0; r < NROWS; r++) begin
      hit[NROWS-1-r] = row_match(MAX_W'(in_data),
                                 MAX_W'(val[r]),
                                 MAX_W'(care[r]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_acc;
      if (in_acc) out_data <= hit;
    end
  end

endmodule

// File: tb/tb_pla_prog_plane.sv
// Self-checking bench for pla_prog_plane (NIN=3, NROWS=4).
// Table vectors, random streams vs. a per-bit reference model.
module tb_pla_prog_plane;

  localparam int NIN   = 3;
  localparam int NROWS = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             prog_start = 1'b0;
  logic             prog_valid = 1'b0;
  logic             prog_ready;
  logic [NIN-1:0]   prog_care = '0;
  logic [NIN-1:0]   prog_val = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NIN-1:0]   in_data = '0;
  logic             out_valid;
  logic [NROWS-1:0] out_data;
  logic             armed;
`ifdef PLA_PROG_PLANE_READBACK_EN
  logic [1:0]       rd_row = '0;
  logic [NIN-1:0]   rd_care;
  logic [NIN-1:0]   rd_val;
`endif

  pla_prog_plane #(.NIN(NIN), .NROWS(NROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_start (prog_start),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_care  (prog_care),
    .prog_val   (prog_val),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
`ifdef PLA_PROG_PLANE_READBACK_EN
    .rd_row     (rd_row),
    .rd_care    (rd_care),
    .rd_val     (rd_val),
`endif
    .armed      (armed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NIN-1:0]   m_care [NROWS];
  logic [NIN-1:0]   m_val  [NROWS];
  logic [NROWS-1:0] exp_out;

  typedef struct {
    logic [NIN-1:0] care;
    logic [NIN-1:0] val;
  } row_t;

  typedef struct {
    logic [NIN-1:0]   din;
    logic [NROWS-1:0] dout;
  } vec_t;

  row_t rows [NROWS];
  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a row matches when every cared column equals its value.
  function automatic logic [NROWS-1:0] model_eval(input logic [NIN-1:0] d);
    logic [NROWS-1:0] res;
    res = '0;
    for (int r = 0; r < NROWS; r++) begin
      logic ok;
      ok = 1'b1;
      for (int b = 0; b < NIN; b++)
        if (m_care[r][b] && (d[b] != m_val[r][b])) ok = 1'b0;
      res[NROWS-1-r] = ok;
    end
    return res;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NROWS; r++) begin
      m_care[r] = '0;
      m_val[r]  = '0;
    end
    exp_out = '0;
  endtask

  task automatic pulse_start();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    check("start_prog_ready", prog_ready, 1);
    check("start_armed", armed, 0);
  endtask

  // Loads NROWS rows with random prog_valid gaps; row0 may be forced.
  task automatic load_random(input bit force0, input bit hold_in);
    int acc = 0;
    int cyc = 0;
    while (acc < NROWS && cyc < 200) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      prog_valid = v;
      if (force0 && acc == 0) begin
        prog_care = '1;
        prog_val  = '1;
      end else begin
        prog_care = NIN'($urandom);
        prog_val  = NIN'($urandom);
      end
      check("load_armed_low", armed, 0);
      check("load_prog_ready", prog_ready, 1);
      check("load_in_ready", in_ready, 0);
      if (hold_in) check("load_no_out", out_valid, 0);
      tick();
      if (v) begin
        m_care[acc] = prog_care;
        m_val[acc]  = prog_val;
        acc++;
      end
      cyc++;
    end
    if (acc < NROWS) check("load_timeout", 0, 1);
    check("load_armed_rise", armed, 1);
    check("load_prog_ready_low", prog_ready, 0);
    prog_valid = 1'b1;
    prog_care  = '1;
    prog_val   = '0;
    tick();
    tick();
    prog_valid = 1'b0;
    check("no_extra_beat_armed", armed, 1);
    check("no_extra_beat_ready", prog_ready, 0);
  endtask

  task automatic rand_eval(input int n);
    for (int i = 0; i < n; i++) begin
      logic v;
      logic [NIN-1:0] d;
      v = 1'($urandom_range(0, 1));
      d = NIN'($urandom);
      in_valid = v;
      in_data  = d;
      check("rand_in_ready", in_ready, 1);
      tick();
      if (v) exp_out = model_eval(d);
      check("rand_out_valid", out_valid, 32'(v));
      check("rand_out_data", out_data, 32'(exp_out));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rows[0] = '{care: 3'b110, val: 3'b100};
    rows[1] = '{care: 3'b001, val: 3'b001};
    rows[2] = '{care: 3'b101, val: 3'b000};
    rows[3] = '{care: 3'b000, val: 3'b000};
    vecs[0] = '{din: 3'b111, dout: 4'b0101};
    vecs[1] = '{din: 3'b000, dout: 4'b0011};
    vecs[2] = '{din: 3'b101, dout: 4'b1101};

    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_prog_ready", prog_ready, 0);
      check("idle_in_ready", in_ready, 0);
      check("idle_out_valid", out_valid, 0);
      check("idle_armed", armed, 0);
    end
    check("idle_out_data", out_data, 0);

    pulse_start();
    for (int r = 0; r < NROWS; r++) begin
      prog_valid = 1'b1;
      prog_care  = rows[r].care;
      prog_val   = rows[r].val;
      check("tbl_armed_low", armed, 0);
      tick();
      m_care[r] = rows[r].care;
      m_val[r]  = rows[r].val;
    end
    prog_valid = 1'b0;
    check("tbl_armed", armed, 1);
    check("tbl_in_ready", in_ready, 1);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].din;
      tick();
      check("tbl_out_valid", out_valid, 1);
      check("tbl_out_data", out_data, 32'(vecs[i].dout));
      check("tbl_model", 32'(model_eval(vecs[i].din)), 32'(vecs[i].dout));
    end
    in_valid = 1'b0;
    exp_out  = vecs[2].dout;
    tick();
    check("hold_out_valid", out_valid, 0);
    check("hold_out_data", out_data, 32'(exp_out));

`ifdef PLA_PROG_PLANE_READBACK_EN
    rd_row = 2'd2;
    tick();
    check("rd_care", rd_care, 3'b101);
    check("rd_val", rd_val, 3'b000);
    rd_row = 2'd0;
    tick();
    check("rd_care0", rd_care, 3'b110);
    check("rd_val0", rd_val, 3'b100);
`endif

    rand_eval(40);

    pulse_start();
    load_random(1'b0, 1'b0);
    rand_eval(30);

    // Restart while a vector is accepted in the same cycle.
    prog_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = NIN'($urandom);
    exp_out    = model_eval(in_data);
    tick();
    prog_start = 1'b0;
    check("inflight_valid", out_valid, 1);
    check("inflight_data", out_data, 32'(exp_out));
    check("inflight_in_ready", in_ready, 0);
    check("inflight_armed", armed, 0);
    tick();
    check("inflight_once", out_valid, 0);
    load_random(1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 3'b111;
    tick();
    in_valid = 1'b0;
    exp_out  = model_eval(3'b111);
    check("reload_valid", out_valid, 1);
    check("reload_msb", out_data[NROWS-1], 1);
    check("reload_data", out_data, 32'(exp_out));
    rand_eval(20);

    // Async reset after two accepted beats.
    pulse_start();
    prog_valid = 1'b1;
    prog_care  = 3'b111;
    prog_val   = 3'b010;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_prog_ready", prog_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_armed", armed, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_prog_ready", prog_ready, 0);
      check("post_rst_armed", armed, 0);
      check("post_rst_in_ready", in_ready, 0);
    end
    prog_valid = 1'b0;
    pulse_start();
    load_random(1'b0, 1'b0);
    rand_eval(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
